// File: rtl/psum_accum.sv
// Cross-pass partial-sum accumulator: sums LANES-wide signed partials over several
// input-channel passes and streams the finished sums out on the last pass.
//
// state | meaning
// IDLE  | waiting for cfg_start
// ACCUM | non-final passes, running sums written to the buffer
// FINAL | last pass, buffer + din streamed out through one output register
// DONE  | one-cycle done pulse, then back to IDLE
`ifndef DATA_INTER_WIDTH
`define DATA_INTER_WIDTH 32
`endif

module psum_accum #(
  parameter int DW    = `DATA_INTER_WIDTH,
  parameter int LANES = 4,
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int PW    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic [AW:0]           cfg_len,
  input  logic [PW-1:0]         cfg_pass,
  output logic                  busy,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [LANES*DW-1:0]   din,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [LANES*DW-1:0]   dout,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, ACCUM, FINAL, DONE} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  state_t              state;
  logic [AW:0]         len_q;
  logic [PW-1:0]       passes_q;
  logic [PW-1:0]       pass;
  logic [AW-1:0]       idx;
  logic                last_taken;
  logic [LANES*DW-1:0] mem [DEPTH];

  logic [AW:0]         len_clamped;
  logic [PW-1:0]       pass_clamped;
  logic [LANES*DW-1:0] rd;
  logic [LANES*DW-1:0] sum;
  logic                beat;
  logic                idx_last;

  function automatic logic [LANES*DW-1:0] sat_add(input logic [LANES*DW-1:0] a,
                                                  input logic [LANES*DW-1:0] b);
    logic [LANES*DW-1:0] r;
    logic [DW:0]         s;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      s = {a[i*DW+DW-1], a[i*DW+:DW]} + {b[i*DW+DW-1], b[i*DW+:DW]};
      // Top two bits disagree only when the DW-bit result overflowed.
      if (s[DW] != s[DW-1])
        r[i*DW+:DW] = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      else
        r[i*DW+:DW] = s[DW-1:0];
    end
    return r;
  endfunction

  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == '0)
      len_clamped = ONE_L;
    else if (cfg_len > DEPTH_L)
      len_clamped = DEPTH_L;
    pass_clamped = (cfg_pass == '0) ? PW'(1) : cfg_pass;
  end

  always_comb begin
    din_ready = 1'b0;
    case (state)
      ACCUM:   din_ready = 1'b1;
      FINAL:   din_ready = !last_taken && (!dout_valid || dout_ready);
      default: din_ready = 1'b0;
    endcase
  end

  assign beat     = din_valid & din_ready;
  assign idx_last = ({1'b0, idx} == (len_q - ONE_L));
  assign rd       = mem[idx];
  assign sum      = sat_add(rd, din);

  // Buffer is overwritten on pass 0, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == ACCUM && beat)
      mem[idx] <= (pass == '0) ? din : sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= '0;
      passes_q   <= '0;
      pass       <= '0;
      idx        <= '0;
      last_taken <= 1'b0;
      busy       <= 1'b0;
      dout_valid <= 1'b0;
      dout       <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            len_q      <= len_clamped;
            passes_q   <= pass_clamped;
            idx        <= '0;
            pass       <= '0;
            last_taken <= 1'b0;
            busy       <= 1'b1;
            state      <= (pass_clamped > PW'(1)) ? ACCUM : FINAL;
          end
        end
        ACCUM: begin
          if (beat) begin
            if (idx_last) begin
              idx  <= '0;
              pass <= pass + 1'b1;
              if (pass == passes_q - PW'(2))
                state <= FINAL;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        FINAL: begin
          if (beat) begin
            dout       <= (passes_q == PW'(1)) ? din : sum;
            dout_valid <= 1'b1;
            idx        <= idx + 1'b1;
            if (idx_last)
              last_taken <= 1'b1;
          end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
            if (last_taken) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum: a table of tiles with hand-computed sums, plus
// hand-written sequences for backpressure, mid-tile reset, clamping and busy starts.
module tb_psum_accum;

  localparam int W = 128;

  logic          clk;
  logic          rst;
  logic          cfg_start;
  logic [6:0]    cfg_len;
  logic [7:0]    cfg_pass;
  logic          busy;
  logic          din_valid;
  logic          din_ready;
  logic [W-1:0]  din;
  logic          dout_valid;
  logic          dout_ready;
  logic [W-1:0]  dout;
  logic          done;

  psum_accum #(.DW(32), .LANES(4), .DEPTH(64), .AW(6), .PW(8)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_pass(cfg_pass),
    .busy(busy), .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]          len;
    logic [7:0]          passes;
    int                  nin;
    int                  nacc;
    int                  nout;
    logic [5:0][W-1:0]   din;
    logic [3:0][W-1:0]   exp;
  } vec_t;

  vec_t         vt[7];
  logic [W-1:0] outq[$];
  int           n_total = 0;
  int           n_pass = 0;
  int           cyc = 0;
  int           done_cnt = 0;
  int           done_cyc = 0;
  int           last_acc = 0;
  int           early = 0;
  logic         phase_accum = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dout_valid && dout_ready) begin
      outq.push_back(dout);
      last_acc = cyc;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (phase_accum && dout_valid) early = early + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mk(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic start(input logic [6:0] l, input logic [7:0] p);
    cfg_start = 1'b1;
    cfg_len   = l;
    cfg_pass  = p;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d);
    bit ok;
    ok = 0;
    din = d;
    din_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (din_ready) begin
        @(posedge clk); #1;
        ok = 1;
      end
    end
    din_valid = 1'b0;
    if (!ok) check("send timeout", 0, 1);
  endtask

  task automatic wait_done(input string nm, input int base);
    bit seen;
    seen = 0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge clk);
      if (done_cnt > base) seen = 1;
    end
    if (!seen) check({nm, " done timeout"}, 0, 1);
    repeat (3) @(negedge clk);
    check({nm, " done pulses"}, done_cnt - base, 1);
    @(posedge clk); #1;
    check({nm, " busy after done"}, busy, 0);
  endtask

  task automatic run_vec(input int k);
    int qb, db;
    string nm;
    nm = $sformatf("vec%0d", k);
    qb = outq.size();
    db = done_cnt;
    early = 0;
    start(vt[k].len, vt[k].passes);
    phase_accum = (vt[k].nacc > 0);
    for (int i = 0; i < vt[k].nin; i++) begin
      if (i == vt[k].nacc) phase_accum = 1'b0;
      send(vt[k].din[i]);
    end
    phase_accum = 1'b0;
    wait_done(nm, db);
    check({nm, " out count"}, outq.size() - qb, vt[k].nout);
    for (int j = 0; j < vt[k].nout; j++)
      if (qb + j < outq.size())
        check($sformatf("%s out%0d", nm, j), outq[qb+j], vt[k].exp[j]);
    check({nm, " early dout_valid"}, early, 0);
    check({nm, " done latency"}, done_cyc - last_acc, 1);
  endtask

  initial begin
    int qb, db, bad;
    time t0;

    foreach (vt[k]) begin
      vt[k].din = '0;
      vt[k].exp = '0;
    end
    // single pass
    vt[0].len = 4; vt[0].passes = 1; vt[0].nin = 4; vt[0].nacc = 0; vt[0].nout = 4;
    for (int i = 0; i < 4; i++) begin
      vt[0].din[i] = mk(i + 1, 101 + i, -(i + 1), 0);
      vt[0].exp[i] = mk(i + 1, 101 + i, -(i + 1), 0);
    end
    // three passes over two positions
    vt[1].len = 2; vt[1].passes = 3; vt[1].nin = 6; vt[1].nacc = 4; vt[1].nout = 2;
    vt[1].din[0] = mk(10, -1, 0, 0);  vt[1].din[1] = mk(20, -2, 0, 0);
    vt[1].din[2] = mk(1, -3, 0, 0);   vt[1].din[3] = mk(2, -4, 0, 0);
    vt[1].din[4] = mk(-5, -5, 0, 0);  vt[1].din[5] = mk(100, -6, 0, 0);
    vt[1].exp[0] = mk(6, -9, 0, 0);   vt[1].exp[1] = mk(122, -12, 0, 0);
    // positive saturation on lane 0 only
    vt[2].len = 1; vt[2].passes = 2; vt[2].nin = 2; vt[2].nacc = 1; vt[2].nout = 1;
    vt[2].din[0] = mk(32'h7FFFFFF0, 5, -7, 0);
    vt[2].din[1] = mk(32'h00000100, 6, 3, 0);
    vt[2].exp[0] = mk(32'h7FFFFFFF, 11, -4, 0);
    // negative saturation on lane 0, near-limit sums elsewhere
    vt[3].len = 1; vt[3].passes = 2; vt[3].nin = 2; vt[3].nacc = 1; vt[3].nout = 1;
    vt[3].din[0] = mk(32'h80000010, 1, 32'h7FFFFFFF, 32'h80000000);
    vt[3].din[1] = mk(32'hFFFFFF00, 2, 32'hFFFFFFFF, 1);
    vt[3].exp[0] = mk(32'h80000000, 3, 32'h7FFFFFFE, 32'h80000001);
    // zero len / zero passes behave as 1x1
    vt[4].len = 0; vt[4].passes = 0; vt[4].nin = 1; vt[4].nacc = 0; vt[4].nout = 1;
    vt[4].din[0] = mk(42, -42, 7, -8);
    vt[4].exp[0] = mk(42, -42, 7, -8);
    // two passes over three positions
    vt[5].len = 3; vt[5].passes = 2; vt[5].nin = 6; vt[5].nacc = 3; vt[5].nout = 3;
    for (int i = 0; i < 3; i++) begin
      vt[5].din[i]     = mk(5 + i, 0, 0, 1000);
      vt[5].din[i + 3] = mk(10 * (i + 1), 0, 0, -1);
      vt[5].exp[i]     = mk(5 + i + 10 * (i + 1), 0, 0, 999);
    end
    // post-reset tile
    vt[6].len = 2; vt[6].passes = 1; vt[6].nin = 2; vt[6].nacc = 0; vt[6].nout = 2;
    vt[6].din[0] = mk(7, 70, 700, -7);  vt[6].din[1] = mk(8, 80, 800, -8);
    vt[6].exp[0] = mk(7, 70, 700, -7);  vt[6].exp[1] = mk(8, 80, 800, -8);

    rst = 1'b1; cfg_start = 1'b0; cfg_len = '0; cfg_pass = '0;
    din_valid = 1'b0; din = '0; dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset busy", busy, 0);
    check("reset din_ready", din_ready, 0);
    check("reset dout_valid", dout_valid, 0);
    check("reset dout", dout, 0);
    check("reset done", done, 0);

    for (int k = 0; k < 6; k++) run_vec(k);

    // backpressure during the final pass
    qb = outq.size();
    db = done_cnt;
    dout_ready = 1'b0;
    start(3, 1);
    send(mk(11, 1, 2, 3));
    din = mk(22, 4, 5, 6);
    din_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp din_ready c%0d", c), din_ready, 0);
      check($sformatf("bp dout_valid c%0d", c), dout_valid, 1);
      check($sformatf("bp dout held c%0d", c), dout, mk(11, 1, 2, 3));
      @(posedge clk); #1;
    end
    dout_ready = 1'b1;
    t0 = $time;
    send(mk(22, 4, 5, 6));
    send(mk(33, 7, 8, 9));
    check("bp throughput", $time - t0, 20);
    wait_done("bp", db);
    check("bp out count", outq.size() - qb, 3);
    if (outq.size() >= qb + 3) begin
      check("bp out0", outq[qb],   mk(11, 1, 2, 3));
      check("bp out1", outq[qb+1], mk(22, 4, 5, 6));
      check("bp out2", outq[qb+2], mk(33, 7, 8, 9));
    end

    // reset in the middle of pass 1
    db = done_cnt;
    start(2, 3);
    send(mk(1, 0, 0, 0));
    send(mk(2, 0, 0, 0));
    send(mk(3, 0, 0, 0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst busy", busy, 0);
    check("rst dout_valid", dout_valid, 0);
    check("rst din_ready", din_ready, 0);
    repeat (4) @(negedge clk);
    check("rst no done", done_cnt - db, 0);
    @(posedge clk); #1;
    run_vec(6);

    // cfg_start while busy is ignored
    qb = outq.size();
    db = done_cnt;
    start(2, 2);
    start(1, 1);
    send(mk(1, 0, 0, 0));
    send(mk(2, 0, 0, 0));
    send(mk(3, 0, 0, 0));
    send(mk(4, 0, 0, 0));
    wait_done("busy start", db);
    check("busy start count", outq.size() - qb, 2);
    if (outq.size() >= qb + 2) begin
      check("busy start out0", outq[qb],   mk(4, 0, 0, 0));
      check("busy start out1", outq[qb+1], mk(6, 0, 0, 0));
    end

    // length above DEPTH clamps to 64 positions
    qb = outq.size();
    db = done_cnt;
    start(100, 1);
    for (int k = 0; k < 64; k++) send(mk(k, -k, 3 * k, 0));
    @(negedge clk);
    check("clamp din_ready after last", din_ready, 0);
    wait_done("clamp", db);
    check("clamp out count", outq.size() - qb, 64);
    bad = 0;
    for (int k = 0; k < 64; k++)
      if (qb + k < outq.size() && outq[qb+k] !== mk(k, -k, 3 * k, 0)) bad++;
    check("clamp data errors", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
